// File: rtl/axi_lite_buf_cfg_if.sv
// axi_lite_channel: AXI-Lite five-channel bundle with master and slave views
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
) (
  input logic clk,
  input logic rstn
);
  logic                      aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0]     aw_addr;
  logic [2:0]                aw_prot;
  logic                      w_valid, w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      b_valid, b_ready;
  logic [1:0]                b_resp;
  logic                      ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0]     ar_addr;
  logic [2:0]                ar_prot;
  logic                      r_valid, r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  modport master (
    input  clk, rstn,
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    input  clk, rstn,
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_buf_cfg.sv
// axi_lite_buf_cfg: per-channel configurable AXI-Lite buffer with outstanding limiters
module axi_lite_buf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);
  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
    assign out_data  = in_data;
    assign empty     = 1'b1;
  end else begin : g_fifo
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rdy, push, pop;
    assign push   = in_valid && rdy;
    assign pop    = out_valid && out_ready;
    assign cnt_nx = cnt + CW'(push) - CW'(pop);
    // ready is registered from next occupancy so the sink's ready never reaches the source
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        rdy <= 1'b0;
      end else begin
        wp  <= push ? (wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1) : wp;
        rp  <= pop ? (rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1) : rp;
        cnt <= cnt_nx;
        rdy <= cnt_nx != CW'(DEPTH);
      end
    always_ff @(posedge clk)
      if (push) mem[wp] <= in_data;
    assign in_ready  = rdy;
    assign out_valid = cnt != '0;
    assign out_data  = mem[rp];
    assign empty     = cnt == '0;
  end
endmodule

module axi_lite_buf_cfg #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2,
  parameter int MAX_WR     = 4,
  parameter int MAX_RD     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_lite_channel.slave               master,
  axi_lite_channel.master              slave,
  output logic [$clog2(MAX_WR+1)-1:0]  wr_pending,
  output logic [$clog2(MAX_RD+1)-1:0]  rd_pending,
  output logic                         idle,
  output logic                         proto_err
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WPW = $clog2(MAX_WR + 1);
  localparam int RPW = $clog2(MAX_RD + 1);
  if ($bits(master.aw_addr) != ADDR_WIDTH || $bits(slave.aw_addr) != ADDR_WIDTH) begin : g_bad_addr
    $fatal(1, "axi_lite_buf_cfg: interface ADDR_WIDTH mismatch");
  end
  if ($bits(master.w_data) != DATA_WIDTH || $bits(slave.w_data) != DATA_WIDTH) begin : g_bad_data
    $fatal(1, "axi_lite_buf_cfg: interface DATA_WIDTH mismatch");
  end
  if (MAX_WR < 1 || MAX_RD < 1) begin : g_bad_max
    $fatal(1, "axi_lite_buf_cfg: MAX_WR and MAX_RD must be >= 1");
  end
  logic                     wr_ok, rd_ok, aw_rdy, ar_rdy;
  logic                     aw_e, w_e, b_e, ar_e, r_e;
  logic                     aw_hs, b_hs, ar_hs, r_hs;
  logic [ADDR_WIDTH+2:0]    aw_d, ar_d;
  logic [DATA_WIDTH+SW-1:0] w_d;
  logic [1:0]               b_d;
  logic [DATA_WIDTH+1:0]    r_d;
  assign wr_ok = wr_pending != WPW'(MAX_WR);
  assign rd_ok = rd_pending != RPW'(MAX_RD);
  assign master.aw_ready = aw_rdy && wr_ok;
  assign master.ar_ready = ar_rdy && rd_ok;
  assign {slave.aw_prot, slave.aw_addr} = aw_d;
  assign {slave.w_strb, slave.w_data}   = w_d;
  assign master.b_resp                  = b_d;
  assign {slave.ar_prot, slave.ar_addr} = ar_d;
  assign {master.r_resp, master.r_data} = r_d;
  axi_lite_buf_fifo #(.W(ADDR_WIDTH + 3), .DEPTH(AW_DEPTH)) u_aw (
    .clk, .rst,
    .in_valid(master.aw_valid && wr_ok), .in_ready(aw_rdy), .in_data({master.aw_prot, master.aw_addr}),
    .out_valid(slave.aw_valid), .out_ready(slave.aw_ready), .out_data(aw_d), .empty(aw_e)
  );
  axi_lite_buf_fifo #(.W(DATA_WIDTH + SW), .DEPTH(W_DEPTH)) u_w (
    .clk, .rst,
    .in_valid(master.w_valid), .in_ready(master.w_ready), .in_data({master.w_strb, master.w_data}),
    .out_valid(slave.w_valid), .out_ready(slave.w_ready), .out_data(w_d), .empty(w_e)
  );
  axi_lite_buf_fifo #(.W(2), .DEPTH(B_DEPTH)) u_b (
    .clk, .rst,
    .in_valid(slave.b_valid), .in_ready(slave.b_ready), .in_data(slave.b_resp),
    .out_valid(master.b_valid), .out_ready(master.b_ready), .out_data(b_d), .empty(b_e)
  );
  axi_lite_buf_fifo #(.W(ADDR_WIDTH + 3), .DEPTH(AR_DEPTH)) u_ar (
    .clk, .rst,
    .in_valid(master.ar_valid && rd_ok), .in_ready(ar_rdy), .in_data({master.ar_prot, master.ar_addr}),
    .out_valid(slave.ar_valid), .out_ready(slave.ar_ready), .out_data(ar_d), .empty(ar_e)
  );
  axi_lite_buf_fifo #(.W(DATA_WIDTH + 2), .DEPTH(R_DEPTH)) u_r (
    .clk, .rst,
    .in_valid(slave.r_valid), .in_ready(slave.r_ready), .in_data({slave.r_resp, slave.r_data}),
    .out_valid(master.r_valid), .out_ready(master.r_ready), .out_data(r_d), .empty(r_e)
  );
  assign aw_hs = master.aw_valid && master.aw_ready;
  assign b_hs  = master.b_valid && master.b_ready;
  assign ar_hs = master.ar_valid && master.ar_ready;
  assign r_hs  = master.r_valid && master.r_ready;
  // a response with nothing outstanding is flagged but still forwarded; the counter saturates at 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_pending <= '0;
      rd_pending <= '0;
      proto_err  <= 1'b0;
    end else begin
      wr_pending <= aw_hs && !b_hs ? wr_pending + 1'b1 :
                    b_hs && !aw_hs && wr_pending != '0 ? wr_pending - 1'b1 : wr_pending;
      rd_pending <= ar_hs && !r_hs ? rd_pending + 1'b1 :
                    r_hs && !ar_hs && rd_pending != '0 ? rd_pending - 1'b1 : rd_pending;
      proto_err  <= proto_err || (b_hs && wr_pending == '0) || (r_hs && rd_pending == '0);
    end
  assign idle = wr_pending == '0 && rd_pending == '0 && aw_e && w_e && b_e && ar_e && r_e;
endmodule

// File: tb/tb_axi_lite_buf_cfg.sv
// tb_axi_lite_buf_cfg: directed stimulus with queue scoreboards checked by a negedge monitor
module tb_axi_lite_buf_cfg;
  localparam int AW = 32, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mi (.clk(clk), .rstn(!rst));
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) si (.clk(clk), .rstn(!rst));
  logic [1:0] wr_pending;
  logic [3:0] rd_pending;
  logic       idle, proto_err;
  axi_lite_buf_cfg #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(0),
    .AR_DEPTH(2), .R_DEPTH(3), .MAX_WR(2), .MAX_RD(8)
  ) dut (
    .clk(clk), .rst(rst), .master(mi), .slave(si),
    .wr_pending(wr_pending), .rd_pending(rd_pending), .idle(idle), .proto_err(proto_err)
  );
  logic auto_b = 1'b0, tb_b_valid = 1'b0;
  assign si.b_valid = tb_b_valid || (auto_b && si.aw_valid && si.aw_ready);
  typedef struct { logic [31:0] a; int c; } aw_t;
  aw_t         exp_aw[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [35:0] exp_w[$];
  aw_t         ea;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (si.aw_valid && si.aw_ready) begin
      chk("aw_q_nonempty", exp_aw.size() != 0, 1);
      if (exp_aw.size() != 0) begin
        ea = exp_aw.pop_front();
        chk("aw_addr", si.aw_addr, ea.a);
        chk("aw_latency", cyc, ea.c);
      end
    end
    if (si.w_valid && si.w_ready) begin
      chk("w_q_nonempty", exp_w.size() != 0, 1);
      if (exp_w.size() != 0) chk("w_beat", {si.w_strb, si.w_data}, exp_w.pop_front());
    end
    if (mi.b_valid && mi.b_ready) begin
      chk("b_q_nonempty", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) chk("b_resp", mi.b_resp, exp_b.pop_front());
    end
    if (mi.r_valid && mi.r_ready) begin
      chk("r_q_nonempty", exp_r.size() != 0, 1);
      if (exp_r.size() != 0) chk("r_beat", {mi.r_resp, mi.r_data}, exp_r.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    mi.aw_valid = 1'b1;
    mi.aw_addr  = a;
    @(negedge clk);
    while (!mi.aw_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("aw_accept", mi.aw_ready, 1);
    if (mi.aw_ready) exp_aw.push_back('{a, cyc + 1});
    tick();
    mi.aw_valid = 1'b0;
  endtask
  task automatic send_b(input logic [1:0] r);
    tb_b_valid = 1'b1;
    si.b_resp  = r;
    exp_b.push_back(r);
    @(negedge clk);
    chk("b_passthrough", mi.b_valid, 1);
    tick();
    tb_b_valid = 1'b0;
  endtask
  initial begin
    int c0, k, n;
    logic [31:0] d;
    logic [35:0] wb [2];
    wb[0] = {4'hF, 32'hDEAD0001};
    wb[1] = {4'h3, 32'h12345678};
    {mi.aw_valid, mi.w_valid, mi.ar_valid, mi.b_ready, mi.r_ready} = '0;
    {mi.aw_addr, mi.ar_addr, mi.w_data} = '0;
    {mi.aw_prot, mi.ar_prot, mi.w_strb} = '0;
    {si.aw_ready, si.w_ready, si.ar_ready, si.r_valid} = '0;
    si.b_resp = '0; si.r_data = '0; si.r_resp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_aw_ready", mi.aw_ready, 0);
    chk("rst_m_w_ready", mi.w_ready, 0);
    chk("rst_m_ar_ready", mi.ar_ready, 0);
    chk("rst_s_r_ready", si.r_ready, 0);
    chk("rst_s_aw_valid", si.aw_valid, 0);
    chk("rst_m_r_valid", mi.r_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_proto_err", proto_err, 0);
    tick();
    rst = 1'b0;
    mi.b_ready = 1'b1; si.aw_ready = 1'b1; si.w_ready = 1'b1; si.ar_ready = 1'b1;
    @(negedge clk);
    chk("pre_edge_aw_ready", mi.aw_ready, 0);
    tick();
    chk("post_aw_ready", mi.aw_ready, 1);
    chk("post_w_ready", mi.w_ready, 1);
    chk("post_ar_ready", mi.ar_ready, 1);
    chk("post_s_r_ready", si.r_ready, 1);
    chk("post_idle", idle, 1);
    chk("post_wr_pending", wr_pending, 0);
    // streaming AW with the downstream answering B in the cycle each AW emerges
    auto_b = 1'b1;
    si.b_resp = 2'b00;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send_aw(32'h1000 + i);
      exp_b.push_back(2'b00);
    end
    chk("stream_cycles", cyc - c0, 8);
    repeat (3) tick();
    auto_b = 1'b0;
    chk("stream_wr_pending", wr_pending, 0);
    for (int i = 0; i < 2; i++) begin
      mi.w_valid = 1'b1;
      {mi.w_strb, mi.w_data} = wb[i];
      @(negedge clk);
      chk("w_accept", mi.w_ready, 1);
      if (mi.w_ready) exp_w.push_back(wb[i]);
      tick();
    end
    mi.w_valid = 1'b0;
    k = 0; n = 0;
    mi.ar_valid = 1'b1;
    while (k < 5 && n < 30) begin
      mi.ar_addr = 32'h4000 + 4 * k;
      @(negedge clk);
      if (mi.ar_ready) k++;
      tick();
      n++;
    end
    mi.ar_valid = 1'b0;
    chk("ar_issued", k, 5);
    chk("rd_pending_5", rd_pending, 5);
    // R backpressure: three beats fill the FIFO, the rest wait across pointer wrap
    mi.r_ready = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      d = 32'hA0 + k;
      si.r_valid = 1'b1; si.r_data = d; si.r_resp = k[1:0];
      @(negedge clk);
      if (si.r_ready) begin
        exp_r.push_back({k[1:0], d});
        k++;
      end
      tick();
    end
    chk("r_bp_accepted", k, 3);
    chk("r_bp_s_ready", si.r_ready, 0);
    mi.r_ready = 1'b1;
    n = 0;
    while (k < 5 && n < 20) begin
      d = 32'hA0 + k;
      si.r_data = d; si.r_resp = k[1:0];
      @(negedge clk);
      if (si.r_ready) begin
        exp_r.push_back({k[1:0], d});
        k++;
      end
      tick();
      n++;
    end
    si.r_valid = 1'b0;
    chk("r_all_accepted", k, 5);
    repeat (5) tick();
    chk("rd_pending_drained", rd_pending, 0);
    chk("r_no_err", proto_err, 0);
    chk("idle_after_r", idle, 1);
    // write limiter at MAX_WR=2
    send_aw(32'h2000);
    send_aw(32'h2004);
    mi.aw_valid = 1'b1;
    mi.aw_addr = 32'h2008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lim_stall", mi.aw_ready, 0);
      tick();
    end
    chk("lim_wr_pending", wr_pending, 2);
    tb_b_valid = 1'b1;
    si.b_resp = 2'b10;
    exp_b.push_back(2'b10);
    @(negedge clk);
    chk("lim_b_cycle_stall", mi.aw_ready, 0);
    tick();
    tb_b_valid = 1'b0;
    @(negedge clk);
    chk("lim_third_accept", mi.aw_ready, 1);
    if (mi.aw_ready) exp_aw.push_back('{32'h2008, cyc + 1});
    tick();
    mi.aw_valid = 1'b0;
    chk("lim_wr_pending_hold", wr_pending, 2);
    send_b(2'b00);
    send_b(2'b01);
    chk("lim_drained", wr_pending, 0);
    // AW accept and B handshake in the same cycle
    send_aw(32'h3000);
    chk("sim_pre", wr_pending, 1);
    mi.aw_valid = 1'b1;
    mi.aw_addr = 32'h3004;
    tb_b_valid = 1'b1;
    si.b_resp = 2'b00;
    exp_b.push_back(2'b00);
    @(negedge clk);
    chk("sim_aw_ready", mi.aw_ready, 1);
    if (mi.aw_ready) exp_aw.push_back('{32'h3004, cyc + 1});
    tick();
    mi.aw_valid = 1'b0;
    tb_b_valid = 1'b0;
    chk("sim_wr_pending", wr_pending, 1);
    send_b(2'b01);
    chk("sim_drained", wr_pending, 0);
    chk("sim_no_err", proto_err, 0);
    // unsolicited B through the passthrough channel
    send_b(2'b11);
    chk("err_set", proto_err, 1);
    chk("err_wr_pending", wr_pending, 0);
    repeat (3) tick();
    chk("err_sticky", proto_err, 1);
    chk("q_aw_empty", exp_aw.size(), 0);
    chk("q_w_empty", exp_w.size(), 0);
    chk("q_b_empty", exp_b.size(), 0);
    chk("q_r_empty", exp_r.size(), 0);
    rst = 1'b1;
    #1;
    chk("err_cleared", proto_err, 0);
    chk("rst_idle_end", idle, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_buf_cfg.md
Name: axi_lite_buf_cfg

Overview:
- Parametrised AXI-Lite buffer placed between an upstream AXI-Lite master and a downstream slave, typically at clock-region or hierarchy boundaries.
- Each of the five channels (AW/W/B/AR/R) has its own depth; depth 0 selects a combinational passthrough.
- Independent write and read outstanding-transaction limiters cap traffic in flight.
- Pending counters and a sticky protocol-error flag are exported for debug and quiesce logic.

Parameters:
- ADDR_WIDTH, 48, address width; must equal both interface ADDR_WIDTH values, else $fatal at elaboration.
- DATA_WIDTH, 64, data width; must equal both interface DATA_WIDTH values; STRB_WIDTH = DATA_WIDTH/8.
- AW_DEPTH, 2, AW channel FIFO entries (0 = passthrough).
- W_DEPTH, 2, W channel FIFO entries (0 = passthrough).
- B_DEPTH, 2, B channel FIFO entries (0 = passthrough).
- AR_DEPTH, 2, AR channel FIFO entries (0 = passthrough).
- R_DEPTH, 2, R channel FIFO entries (0 = passthrough).
- MAX_WR, 4, maximum outstanding writes; must be >= 1.
- MAX_RD, 4, maximum outstanding reads; must be >= 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- master  axi_lite_channel.slave  -  upstream side; the block acts as slave here.
- slave  axi_lite_channel.master  -  downstream side; the block acts as master here.
- wr_pending  output  $clog2(MAX_WR+1)  writes accepted on master AW but not yet completed on master B.
- rd_pending  output  $clog2(MAX_RD+1)  reads accepted on master AR but not yet completed on master R.
- idle  output  1  high when wr_pending==0, rd_pending==0 and all FIFOs are empty.
- proto_err  output  1  sticky flag, cleared only by rst.

Behaviour:
- One clock only; the interface clk/rstn signals are not used.
- Reset (async assert, sync release): all FIFOs empty, all downstream/upstream valids 0, all readies 0, pending counters 0, proto_err 0, idle 1.
- Readies are registered and rise on the first clk edge after rst deasserts.
- Depth N >= 1 channel FIFO:
  - Ring buffer of N entries with read/write pointers and an occupancy count.
  - w_ready = !full, registered; there is no combinational path from the sink's ready.
  - r_valid = !empty; no fall-through, so an entry written at edge k is visible at the output after edge k.
  - Minimum latency is 1 cycle.
  - Depth 1 gives half throughput; depth >= 2 sustains one beat per cycle.
  - Simultaneous push and pop while full is not permitted (push is blocked because ready is low).
  - Simultaneous push and pop while partially full leaves occupancy unchanged.
  - Pointers wrap modulo N; N need not be a power of two.
  - Output payload is stable while valid && !ready, per AXI rules.
- Depth 0: valid, ready and payload are wired straight through; 0 cycles latency.
- Write limiter:
  - master.aw_ready is forced 0 when wr_pending == MAX_WR.
  - wr_pending increments on a master AW handshake and decrements on a master B handshake.
  - Both in the same cycle leaves it unchanged.
- Read limiter: identical behaviour, using AR and R with rd_pending and MAX_RD.
- Limiter gating applies after the AW/AR FIFO ready: master ready = fifo_ready && (pending < MAX).
- Underflow: a master B (or R) handshake while the matching pending count is 0 sets proto_err, and the counter holds at 0.
  - The response is still forwarded.
- AW and W are independent; W beats may lead or trail AW. The W channel is not gated by the limiter.
- Reset mid-transfer: all buffered beats are discarded and counters clear. The environment must also reset both sides.

Test Plan:
- Reset release: rst held 3 cycles then dropped -> all valids 0 during reset; all readies 1 on the first edge after; idle=1, wr_pending=0.
- Streaming, AW_DEPTH=2: AW addrs 0x1000..0x1007 one per cycle with slave.aw_ready=1 -> 8 accepts in 8 cycles, each output 1 cycle after its input, order preserved.
- Backpressure/wrap, R_DEPTH=3: push 5 R beats with master.r_ready=0 -> 3 accepted, slave.r_ready=0. Then r_ready=1 -> beats emerge in order 0..4 with data and resp intact across pointer wrap.
- Limiter, MAX_WR=2: 3 AWs issued with no B returned -> third stalls and wr_pending=2. One B delivered -> third accepted next cycle, wr_pending stays at 2.
- Simultaneous events: AW accept and B handshake in the same cycle at wr_pending=1 -> wr_pending stays 1.
- Error and passthrough, B_DEPTH=0: slave issues a B with wr_pending=0 -> master.b_valid high in the same cycle; proto_err=1 and remains 1 until rst.
